// File: rtl/flag_ctrl_pkg.sv
// Shared encodings for flag_ctrl: op classes, condition codes, FSM states, PSW layout.
// Pure declarations plus the PSW packing helper; no logic of its own.
package flag_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP         = 3'd0,
        OP_ALU_ALL     = 3'd1,
        OP_ALU_NOCY    = 3'd2,
        OP_CY_ONLY     = 3'd3,
        OP_COND_TEST   = 3'd4,
        OP_PSW_SAVE    = 3'd5,
        OP_PSW_RESTORE = 3'd6,
        OP_RSVD        = 3'd7
    } op_class_e;

    typedef enum logic [2:0] {
        CC_NZ = 3'd0,
        CC_Z  = 3'd1,
        CC_NC = 3'd2,
        CC_C  = 3'd3,
        CC_PO = 3'd4,
        CC_PE = 3'd5,
        CC_P  = 3'd6,
        CC_M  = 3'd7
    } cond_code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STK_WR = 2'd1,
        ST_STK_RD = 2'd2
    } state_e;

    typedef struct packed {
        logic s;
        logic z;
        logic ac;
        logic p;
        logic cy;
    } flags_t;

    localparam int PSW_S   = 7;
    localparam int PSW_Z   = 6;
    localparam int PSW_AC  = 4;
    localparam int PSW_P   = 2;
    localparam int PSW_ONE = 1;
    localparam int PSW_CY  = 0;

    function automatic logic [7:0] psw_image(input flags_t f);
        logic [7:0] img;
        img          = '0;
        img[PSW_S]   = f.s;
        img[PSW_Z]   = f.z;
        img[PSW_AC]  = f.ac;
        img[PSW_P]   = f.p;
        img[PSW_ONE] = 1'b1;
        img[PSW_CY]  = f.cy;
        return img;
    endfunction

endpackage

// File: rtl/flag_ctrl_if.sv
// Operation handshake, flag outputs and PSW stack port of flag_ctrl.
// master = requester / stack side, slave = flag_ctrl.
interface flag_ctrl_if;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_class;
    logic [2:0] cond_code;
    logic       is_zero, is_parity, is_sign, is_carry, is_aux;
    logic       flg_zero, flg_parity, flg_sign, flg_carry, flg_aux;
    logic       cond_true;
    logic       op_done;
    logic       stk_req, stk_we;
    logic [7:0] stk_wdata;
    logic [7:0] stk_rdata;
    logic       stk_ack;

    modport master (
        output op_valid, op_class, cond_code,
        output is_zero, is_parity, is_sign, is_carry, is_aux,
        output stk_rdata, stk_ack,
        input  op_ready, cond_true, op_done,
        input  flg_zero, flg_parity, flg_sign, flg_carry, flg_aux,
        input  stk_req, stk_we, stk_wdata
    );

    modport slave (
        input  op_valid, op_class, cond_code,
        input  is_zero, is_parity, is_sign, is_carry, is_aux,
        input  stk_rdata, stk_ack,
        output op_ready, cond_true, op_done,
        output flg_zero, flg_parity, flg_sign, flg_carry, flg_aux,
        output stk_req, stk_we, stk_wdata
    );
endinterface

// File: rtl/flag_ctrl_cond_eval.sv
// Evaluates a condition code against the current flags.
// Purely combinational, zero latency; no handshake.
module flag_ctrl_cond_eval
    import flag_ctrl_pkg::*;
(
    input  logic [2:0] cond_code,
    input  logic       zero,
    input  logic       carry,
    input  logic       parity,
    input  logic       sign,
    output logic       cond_true
);
    always_comb begin
        cond_true = 1'b0;
        case (cond_code_e'(cond_code))
            CC_NZ:   cond_true = ~zero;
            CC_Z:    cond_true = zero;
            CC_NC:   cond_true = ~carry;
            CC_C:    cond_true = carry;
            CC_PO:   cond_true = ~parity;
            CC_PE:   cond_true = parity;
            CC_P:    cond_true = ~sign;
            CC_M:    cond_true = sign;
            default: cond_true = 1'b0;
        endcase
    end
endmodule

// File: rtl/flag_ctrl.sv
// Processor flag register with ALU update, condition test and PSW save/restore over a stack port.
// Single-cycle classes finish one cycle after accept; PSW ops hold until stk_ack, op_ready low meanwhile.
// Backpressure: op_valid outside IDLE is dropped. FLAG_CTRL_AUX_EN enables the AC flag.
module flag_ctrl
    import flag_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    flag_ctrl_if.slave  op_if
);
    state_e    state_q, state_d;
    flags_t    flg_q, alu_flg, rd_flg;
    op_class_e op_cls;
    logic      accept, ack_vld, cond_res, cond_q, done_q;
    logic      alu_ac, rd_ac;
    logic [2:0] unused_rdata;

    assign op_cls  = op_class_e'(op_if.op_class);
    assign accept  = op_if.op_valid && (state_q == ST_IDLE);
    assign ack_vld = op_if.stk_ack && (state_q != ST_IDLE);
    assign unused_rdata = {op_if.stk_rdata[5], op_if.stk_rdata[3], op_if.stk_rdata[PSW_ONE]};

`ifdef FLAG_CTRL_AUX_EN
    assign alu_ac        = op_if.is_aux;
    assign rd_ac         = op_if.stk_rdata[PSW_AC];
    assign op_if.flg_aux = flg_q.ac;
`else
    logic [1:0] unused_aux;
    assign unused_aux    = {op_if.is_aux, op_if.stk_rdata[PSW_AC]};
    assign alu_ac        = 1'b0;
    assign rd_ac         = 1'b0;
    assign op_if.flg_aux = 1'b0;
`endif

    always_comb begin
        alu_flg.s  = op_if.is_sign;
        alu_flg.z  = op_if.is_zero;
        alu_flg.ac = alu_ac;
        alu_flg.p  = op_if.is_parity;
        alu_flg.cy = op_if.is_carry;
        rd_flg.s   = op_if.stk_rdata[PSW_S];
        rd_flg.z   = op_if.stk_rdata[PSW_Z];
        rd_flg.ac  = rd_ac;
        rd_flg.p   = op_if.stk_rdata[PSW_P];
        rd_flg.cy  = op_if.stk_rdata[PSW_CY];
    end

    flag_ctrl_cond_eval u_cond_eval (
        .cond_code (op_if.cond_code),
        .zero      (flg_q.z),
        .carry     (flg_q.cy),
        .parity    (flg_q.p),
        .sign      (flg_q.s),
        .cond_true (cond_res)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && op_cls == OP_PSW_SAVE)    state_d = ST_STK_WR;
                if (accept && op_cls == OP_PSW_RESTORE) state_d = ST_STK_RD;
            end
            ST_STK_WR, ST_STK_RD: if (op_if.stk_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Flags cannot change outside IDLE, so the write image is stable for the whole transfer.
    always_comb begin
        op_if.op_ready  = 1'b0;
        op_if.stk_req   = 1'b0;
        op_if.stk_we    = 1'b0;
        op_if.stk_wdata = '0;
        case (state_q)
            ST_IDLE:   op_if.op_ready = 1'b1;
            ST_STK_WR: begin
                op_if.stk_req   = 1'b1;
                op_if.stk_we    = 1'b1;
                op_if.stk_wdata = psw_image(flg_q);
            end
            ST_STK_RD: op_if.stk_req = 1'b1;
            default:   op_if.op_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flg_q  <= '0;
            cond_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= ack_vld ||
                      (accept && op_cls != OP_PSW_SAVE && op_cls != OP_PSW_RESTORE);
            if (accept) begin
                case (op_cls)
                    OP_ALU_ALL:   flg_q    <= alu_flg;
                    OP_ALU_NOCY:  flg_q    <= {alu_flg.s, alu_flg.z, alu_flg.ac, alu_flg.p, flg_q.cy};
                    OP_CY_ONLY:   flg_q.cy <= op_if.is_carry;
                    OP_COND_TEST: cond_q   <= cond_res;
                    default:      ;
                endcase
            end
            if (ack_vld && state_q == ST_STK_RD) flg_q <= rd_flg;
        end
    end

    assign op_if.flg_zero   = flg_q.z;
    assign op_if.flg_parity = flg_q.p;
    assign op_if.flg_sign   = flg_q.s;
    assign op_if.flg_carry  = flg_q.cy;
    assign op_if.cond_true  = cond_q;
    assign op_if.op_done    = done_q;
endmodule
